// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported data memory between the CPU pipeline MEM stage and
// a debug/loader port. Every access walks the same four-state sequence
// (IDLE -> ISSUE -> WAIT -> DONE), so an access takes four cycles from the
// cycle its request is sampled to its one-cycle ack. The pipeline is stalled
// while a CPU request is pending. A bounded-wait counter stops a busy CPU
// from starving the debug port.
//
// Optional feature (macro DMEM_ARB_PERF_EN):
//   When defined, adds two free-running performance counters:
//     perf_stall_cycles : cycles with cpu_stall high (wraps at 2^32)
//     perf_dbg_grants   : number of debug grants     (wraps at 2^16)
//   When undefined, the ports and counters are absent.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   cpu_rd/cpu_wr           CPU read / write request (write wins if both)
//   cpu_addr/cpu_wdata      CPU address / write data
//   cpu_rdata               CPU read data, held until the next CPU read
//   cpu_ack                 CPU access complete (1-cycle pulse)
//   cpu_stall               combinational pipeline stall
//   dbg_req/dbg_we          debug request / write enable
//   dbg_addr/dbg_wdata      debug address / write data
//   dbg_rdata               debug read data, held until the next debug read
//   dbg_ack                 debug access complete (1-cycle pulse)
//   mem_rd/mem_wr           registered memory strobes (ISSUE cycle only)
//   mem_addr/mem_wdata      registered memory address / write data
//   mem_rdata               memory read data, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU (MEM stage) side
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  // Debug / loader side
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  // Data memory side
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [15:0]       perf_dbg_grants
`endif
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  // Counter wide enough to hold DBG_MAX_WAIT; at least one bit so that
  // DBG_MAX_WAIT = 0 (debug always wins) still elaborates.
  localparam int CNT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DBG_MAX_WAIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,        state_d;
  logic              owner_q,        owner_d;
  logic              op_wr_q,        op_wr_d;
  logic [CNT_W-1:0]  dbg_wait_cnt_q, dbg_wait_cnt_d;
  logic              mem_rd_q,       mem_rd_d;
  logic              mem_wr_q,       mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
  logic              cpu_ack_q,      cpu_ack_d;
  logic              dbg_ack_q,      dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q,    cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q,    dbg_rdata_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic cpu_req;
  logic dbg_priority;
  logic grant_dbg;
  logic grant_cpu;
  logic in_idle;

  assign cpu_req      = cpu_rd | cpu_wr;
  assign in_idle      = (state_q == IDLE);
  // Debug wins a tie only once it has lost DBG_MAX_WAIT times in a row.
  assign dbg_priority = (dbg_wait_cnt_q >= MAX_CNT);
  assign grant_dbg    = in_idle & dbg_req & (~cpu_req | dbg_priority);
  assign grant_cpu    = in_idle & cpu_req & ~grant_dbg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    op_wr_d        = op_wr_q;
    dbg_wait_cnt_d = dbg_wait_cnt_q;
    mem_rd_d       = 1'b0;
    mem_wr_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_ack_d      = 1'b0;
    dbg_ack_d      = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    dbg_rdata_d    = dbg_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_dbg) begin
          owner_d        = OWNER_DBG;
          op_wr_d        = dbg_we;
          mem_addr_d     = dbg_addr;
          mem_wdata_d    = dbg_wdata;
          mem_rd_d       = ~dbg_we;
          mem_wr_d       = dbg_we;
          dbg_wait_cnt_d = '0;
          state_d        = ISSUE;
        end else if (grant_cpu) begin
          owner_d     = OWNER_CPU;
          // Write takes precedence when both strobes are high.
          op_wr_d     = cpu_wr;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_rd_d    = ~cpu_wr;
          mem_wr_d    = cpu_wr;
          if (dbg_req && (dbg_wait_cnt_q < MAX_CNT)) begin
            dbg_wait_cnt_d = dbg_wait_cnt_q + CNT_W'(1);
          end
          state_d     = ISSUE;
        end
      end

      // Strobes were registered on entry, so they are high for this one cycle.
      ISSUE: state_d = WAIT;

      // mem_rdata is valid here; capture it and raise the ack together so both
      // appear in DONE.
      WAIT: begin
        if (owner_q == OWNER_DBG) begin
          dbg_ack_d = 1'b1;
          if (!op_wr_q) dbg_rdata_d = mem_rdata;
        end else begin
          cpu_ack_d = 1'b1;
          if (!op_wr_q) cpu_rdata_d = mem_rdata;
        end
        state_d = DONE;
      end

      DONE:    state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= OWNER_CPU;
      op_wr_q        <= 1'b0;
      dbg_wait_cnt_q <= '0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_ack_q      <= 1'b0;
      dbg_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      dbg_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      op_wr_q        <= op_wr_d;
      dbg_wait_cnt_q <= dbg_wait_cnt_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_ack_q      <= cpu_ack_d;
      dbg_ack_q      <= dbg_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      dbg_rdata_q    <= dbg_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

  // Drops in the ack cycle so the pipeline advances exactly when data is ready.
  assign cpu_stall = cpu_req & ~cpu_ack_q;

`ifdef DMEM_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap naturally)
  // ---------------------------------------------------------------------------
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [15:0] perf_dbg_grants_q,   perf_dbg_grants_d;

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q + 32'(cpu_stall);
    perf_dbg_grants_d   = perf_dbg_grants_q + 16'(grant_dbg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles_q <= '0;
      perf_dbg_grants_q   <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_dbg_grants_q   <= perf_dbg_grants_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_dbg_grants   = perf_dbg_grants_q;
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rd_q && mem_wr_q));
  a_ack_excl: assert property (@(posedge clk) disable iff (!reset)
    !(cpu_ack_q && dbg_ack_q));
  a_strobe_in_issue: assert property (@(posedge clk) disable iff (!reset)
    (mem_rd_q || mem_wr_q) |-> (state_q == ISSUE));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed self-checking bench for dmem_arbiter (DBG_MAX_WAIT = 2). A small
// behavioural memory answers the strobes with one cycle of read latency.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_ack;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [15:0]   perf_dbg_grants;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .DBG_MAX_WAIT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dbg_grants   (perf_dbg_grants)
`endif
  );

  // Behavioural single-ported memory, read data one cycle after mem_rd.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one CPU access starting at a falling edge with the FSM idle. Sample 0
  // is the request cycle; the ack is expected at sample 3.
  task automatic cpu_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int ack_at, output int stall_n,
                            output int rd_n, output int wr_n, output logic [DW-1:0] rdata);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    ack_at = -1; stall_n = 0; rd_n = 0; wr_n = 0; rdata = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (cpu_stall) stall_n++;
      if (mem_rd) rd_n++;
      if (mem_wr) wr_n++;
      if (cpu_ack) begin
        ack_at = i; rdata = cpu_rdata; cpu_rd = 1'b0; cpu_wr = 1'b0;
      end
      @(negedge clk);
      if (ack_at >= 0) break;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int ack_at, output logic [DW-1:0] rdata);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    ack_at = -1; rdata = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (dbg_ack) begin
        ack_at = i; rdata = dbg_rdata; dbg_req = 1'b0;
      end
      @(negedge clk);
      if (ack_at >= 0) break;
    end
    dbg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ack_at, stall_n, rd_n, wr_n, lat, n_acks, cpu_since_dbg;
    logic [DW-1:0] rdata;
    logic [5:0]    order;

    // ---- Reset hold with a pending CPU write ----
    reset = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset_outputs_zero",
            64'({mem_rd, mem_wr, mem_addr, mem_wdata, cpu_ack, dbg_ack} | 64'(cpu_rdata) | 64'(dbg_rdata)),
            64'(0));
    end
    reset = 1'b1;
    @(negedge clk); #1;
    check("post_reset_mem_wr", 64'(mem_wr), 64'(1));
    check("post_reset_mem_addr", 64'(mem_addr), 64'(9'h010));
    check("post_reset_mem_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    lat = -1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk); #1;
      if (cpu_ack) begin lat = i; cpu_wr = 1'b0; break; end
    end
    check("post_reset_ack_lat", 64'(lat), 64'(2));
    @(negedge clk);

    // ---- CPU write then read ----
    cpu_access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, ack_at, stall_n, rd_n, wr_n, rdata);
    check("cpu_wr_ack_at", 64'(ack_at), 64'(3));
    check("cpu_wr_stall", 64'(stall_n), 64'(3));
    check("cpu_wr_strobes", 64'({rd_n[3:0], wr_n[3:0]}), 64'(8'h01));
    cpu_access(1'b1, 1'b0, 9'h010, 32'h0, ack_at, stall_n, rd_n, wr_n, rdata);
    check("cpu_rd_ack_at", 64'(ack_at), 64'(3));
    check("cpu_rd_stall", 64'(stall_n), 64'(3));
    check("cpu_rd_strobes", 64'({rd_n[3:0], wr_n[3:0]}), 64'(8'h10));
    check("cpu_rd_data", 64'(rdata), 64'(32'hDEADBEEF));
    #1;
    check("cpu_rdata_hold", 64'(cpu_rdata), 64'(32'hDEADBEEF));

    // ---- Simultaneous read+write is a write ----
    cpu_access(1'b1, 1'b1, 9'h005, 32'h12345678, ack_at, stall_n, rd_n, wr_n, rdata);
    check("rdwr_ack_at", 64'(ack_at), 64'(3));
    check("rdwr_strobes", 64'({rd_n[3:0], wr_n[3:0]}), 64'(8'h01));
    check("rdwr_rdata_unchanged", 64'(rdata), 64'(32'hDEADBEEF));
    cpu_access(1'b1, 1'b0, 9'h005, 32'h0, ack_at, stall_n, rd_n, wr_n, rdata);
    check("rdwr_readback", 64'(rdata), 64'(32'h12345678));

    // ---- Debug write of 0x1FF ----
    dbg_access(1'b1, 9'h1FF, 32'hCAFE01FF, ack_at, rdata);
    check("dbg_wr_ack_at", 64'(ack_at), 64'(3));
    check("dbg_wr_rdata_zero", 64'(rdata), 64'(0));

    // ---- Contention, DBG_MAX_WAIT = 2: expect C C D C C D ----
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 9'h005;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
    order = '0; n_acks = 0; cpu_since_dbg = 0;
    for (int i = 0; i < 40 && n_acks < 6; i++) begin
      #1;
      if (cpu_ack) begin
        order[n_acks] = 1'b0; n_acks++;
        cpu_since_dbg++;
        check("cont_wait_cnt_cpu", 64'(dut.dbg_wait_cnt_q), 64'(cpu_since_dbg));
        check("cont_cpu_rdata", 64'(cpu_rdata), 64'(32'h12345678));
      end
      if (dbg_ack) begin
        order[n_acks] = 1'b1; n_acks++;
        cpu_since_dbg = 0;
        check("cont_wait_cnt_dbg", 64'(dut.dbg_wait_cnt_q), 64'(0));
        check("cont_dbg_rdata", 64'(dbg_rdata), 64'(32'hCAFE01FF));
      end
      @(negedge clk);
    end
    cpu_rd = 1'b0; dbg_req = 1'b0;
    check("cont_ack_count", 64'(n_acks), 64'(6));
    check("cont_grant_order", 64'(order), 64'(6'b100100));
    @(negedge clk); @(negedge clk);

    // ---- Reset during WAIT of a debug read ----
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h1FF;
    @(negedge clk); @(negedge clk); #1;
    check("rst_wait_state_before", 64'(dut.state_q), 64'(2));
    reset = 1'b0; #1;
    check("rst_wait_no_ack", 64'(dbg_ack), 64'(0));
    check("rst_wait_rdata", 64'(dbg_rdata), 64'(0));
    check("rst_wait_state", 64'(dut.state_q), 64'(0));
    dbg_req = 1'b0;
    @(negedge clk); #1;
    check("rst_wait_no_ack_later", 64'(dbg_ack), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    dbg_access(1'b0, 9'h1FF, 32'h0, ack_at, rdata);
    check("reissue_ack_at", 64'(ack_at), 64'(3));
    check("reissue_rdata", 64'(rdata), 64'(32'hCAFE01FF));

`ifdef DMEM_ARB_PERF_EN
    // ---- Performance counters from a fresh reset ----
    reset = 1'b0;
    @(negedge clk); #1;
    check("perf_reset", 64'({perf_stall_cycles, perf_dbg_grants}), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    cpu_access(1'b0, 1'b1, 9'h020, 32'h0BADF00D, ack_at, stall_n, rd_n, wr_n, rdata);
    cpu_access(1'b1, 1'b0, 9'h020, 32'h0, ack_at, stall_n, rd_n, wr_n, rdata);
    dbg_access(1'b0, 9'h020, 32'h0, ack_at, rdata);
    #1;
    check("perf_stall_cycles", 64'(perf_stall_cycles), 64'(6));
    check("perf_dbg_grants", 64'(perf_dbg_grants), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Multi-cycle arbiter sharing the single-ported data memory between the CPU pipeline MEM stage and a debug/loader port.
- Sits between the Datapath MEM-stage memory strobes (MemRead/MemWrite, 9-bit address, 32-bit data) and the data memory.
- Sequences each access through a fixed 4-state FSM and raises a stall to the pipeline while a CPU access is pending.
- Prevents debug starvation with a bounded-wait counter.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 9, data memory address width.
- DBG_MAX_WAIT, 4, lost-arbitration count after which debug gets priority (0 means debug always has priority).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (low = reset)
- cpu_rd  in  1  CPU read request (MemRead, MEM stage)
- cpu_wr  in  1  CPU write request (MemWrite, MEM stage)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data
- cpu_ack  out  1  CPU access complete, 1-cycle pulse
- cpu_stall  out  1  pipeline stall
- dbg_req  in  1  debug request
- dbg_we  in  1  debug write enable (1 = write, 0 = read)
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_rdata  out  DATA_W  debug read data
- dbg_ack  out  1  debug access complete, 1-cycle pulse
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd

Behaviour:
- Reset (reset low, asynchronous) drives all of the following to 0, and they stay 0 until reset is released:
  - state = IDLE
  - all outputs: mem_rd, mem_wr, mem_addr, mem_wdata, cpu_ack, dbg_ack, cpu_rdata, dbg_rdata
  - owner and dbg_wait_cnt
- A reset mid-access aborts the access with no ack.
- cpu_req = cpu_rd | cpu_wr. If both are high, the access is a write.
- Requesters hold request, address and data stable until their ack.
- FSM IDLE:
  - Samples requests.
  - If cpu_req only, grant CPU. If dbg_req only, grant debug.
  - If both, grant debug when dbg_wait_cnt >= DBG_MAX_WAIT, else grant CPU.
  - On a grant: latch owner, op, addr and wdata; go to ISSUE.
  - If no request, stay in IDLE.
- FSM ISSUE:
  - mem_rd/mem_wr (registered) high for exactly this one cycle; mem_addr/mem_wdata = latched values.
  - Go to WAIT.
- FSM WAIT:
  - For a read, capture mem_rdata into the owner's rdata register at the end of this cycle.
  - For a write, rdata is unchanged.
  - Go to DONE.
- FSM DONE:
  - Owner's ack high for exactly this cycle. Go to IDLE.
- Latency: request sampled in IDLE at cycle N; strobe in N+1; ack and valid rdata in N+3. Maximum throughput is 1 access per 4 cycles.
- rdata outputs hold their last read value until the next read completes for that requester.
- mem_addr/mem_wdata hold their last value outside ISSUE. mem_rd/mem_wr are never both high.
- dbg_wait_cnt:
  - Increments in each IDLE cycle where CPU is granted while dbg_req is high.
  - Saturates at DBG_MAX_WAIT.
  - Clears to 0 when debug is granted.
- cpu_stall = cpu_req & ~cpu_ack (combinational). It is high from the first request cycle through the cycle before the ack, and low in the ack cycle.
- A requester that keeps its request high after its ack is treated as a new request in the following IDLE cycle.
- A request that appears while the FSM is busy waits, with no loss, until the next IDLE.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cycles (32 bits).
  - Counts every cycle cpu_stall is high; wraps at 2^32; reset to 0.
  - Adds output perf_dbg_grants (16 bits), counting debug grants; wraps at 2^16; reset to 0.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Reset hold: reset low for 3 cycles with cpu_wr=1 -> all outputs 0, no mem_wr; after release, write issues 1 cycle later.
- CPU write then read: cpu_wr addr=0x010 data=0xDEADBEEF, then cpu_rd addr=0x010 -> each access takes 4 cycles from sample to ack; cpu_rdata = 0xDEADBEEF on the read ack; cpu_stall is high for 3 cycles per access.
- Contention with DBG_MAX_WAIT=2: CPU and debug request continuously, debug reads 0x1FF -> grant order is CPU, CPU, DBG, CPU, CPU, DBG; dbg_wait_cnt resets to 0 after each debug grant.
- Simultaneous cpu_rd=1 and cpu_wr=1 at 0x005 with data 0x12345678 -> only mem_wr pulses; a later read of 0x005 returns 0x12345678.
- Reset asserted in WAIT during a debug read -> no dbg_ack, dbg_rdata = 0, state = IDLE; a re-issued read completes normally.
- DMEM_ARB_PERF_EN defined: 2 CPU accesses plus 1 debug access -> perf_stall_cycles = 6 and perf_dbg_grants = 1.
